frame_strobe_col_gen: RTL and testbench

- Column-base frame strobe generator: the originating end of the per-column FrameStrobe chain that terminal tiles buffer and pass on.
- Accepts frame write requests (column address and frame index) from the configuration controller. When the column matches, it drives a one-hot FrameStrobe_O pulse into the bottom tile of the column, with programmable setup and width so FrameData is stable around the strobe.

---
 rtl/frame_strobe_col_gen.sv | 127 ++++++++++++
 tb/tb_frame_strobe_col_gen.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_strobe_col_gen.sv
// frame_strobe_col_gen
// Column-base FrameStrobe generator. This is the originating end of one
// column's FrameStrobe chain. It takes frame write requests from the
// configuration controller and, when the column address matches ColId,
// drives a one-hot strobe into the bottom tile. The strobe has a
// programmable setup time and width, so FrameData is stable around it.
//
// Optional feature: define FRAME_STROBE_BCAST_EN so that the all-ones
// column address matches every instance (broadcast). ColId must not be
// all-ones when this is enabled. Without the macro, all-ones is an
// ordinary column address.
module frame_strobe_col_gen #(
    parameter int MaxFramesPerCol = 36,
    parameter int FrameIdxWidth   = 6,
    parameter int ColSelWidth     = 5,
    parameter int ColId           = 0,
    parameter int SetupCycles     = 1,
    parameter int StrobeCycles    = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Req,
    input  logic [ColSelWidth-1:0]     ReqCol,
    input  logic [FrameIdxWidth-1:0]   ReqFrame,
    output logic                       Ready,
    input  logic                       Abort,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                       Busy,
    output logic                       ErrRange,
    output logic [15:0]                StrobeCount
);

    // The shared down-counter must hold the setup load (which includes
    // the capture cycle) and the strobe-width load.
    localparam int CntMax   = (SetupCycles > StrobeCycles) ? SetupCycles : StrobeCycles;
    localparam int CntWidth = $clog2(CntMax + 1);

    localparam logic [FrameIdxWidth:0]   FrameLimit = (FrameIdxWidth + 1)'(MaxFramesPerCol);
    localparam logic [ColSelWidth-1:0]   OwnCol     = ColSelWidth'(ColId);
    localparam logic [MaxFramesPerCol-1:0] StrobeLsb = MaxFramesPerCol'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        GUARD
    } state_t;

    state_t                     state;
    logic [CntWidth-1:0]        cnt;
    logic [FrameIdxWidth-1:0]   frame_q;
    logic                       accept;
    logic                       col_match;
    logic                       frame_ok;

    assign Ready    = (state == IDLE) & ~RST;
    assign Busy     = (state != IDLE);
    assign accept   = Req & Ready;
    assign frame_ok = ({1'b0, ReqFrame} < FrameLimit);

`ifdef FRAME_STROBE_BCAST_EN
    assign col_match = (ReqCol == OwnCol) | (ReqCol == {ColSelWidth{1'b1}});
`else
    assign col_match = (ReqCol == OwnCol);
`endif

    // Request FSM with a registered strobe, range-error pulse and strobe counter.
    // The setup count is loaded one higher than SetupCycles-1 because the cycle
    // after accept is spent with the request sitting in the capture register.
    // That places the strobe SetupCycles+1 edges after accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            cnt           <= '0;
            frame_q       <= '0;
            FrameStrobe_O <= '0;
            ErrRange      <= 1'b0;
            StrobeCount   <= '0;
        end else begin
            ErrRange <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        frame_q <= ReqFrame;
                        if (col_match) begin
                            if (frame_ok) begin
                                state <= SETUP;
                                cnt   <= CntWidth'(SetupCycles);
                            end else begin
                                ErrRange <= 1'b1;
                            end
                        end
                    end
                end
                SETUP: begin
                    if (Abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state         <= STROBE;
                        FrameStrobe_O <= StrobeLsb << frame_q;
                        cnt           <= CntWidth'(StrobeCycles - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state         <= GUARD;
                        FrameStrobe_O <= '0;
                        StrobeCount   <= StrobeCount + 16'd1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GUARD: begin
                    state <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    FrameStrobe_O <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_strobe_col_gen.sv
// tb_frame_strobe_col_gen
// Drives two frame_strobe_col_gen instances, both with ColId=3:
//   dut_a uses the default timing.
//   dut_b uses SetupCycles=3, StrobeCycles=2.
// Expected waveforms come from the timing rules, expressed as offsets
// from the accept edge. FRAME_STROBE_BCAST_EN selects the broadcast
// expectation.
module tb_frame_strobe_col_gen;

    localparam logic [4:0] ColIdTb = 5'd3;
    localparam int SetupB  = 3;
    localparam int StrobeB = 2;
`ifdef FRAME_STROBE_BCAST_EN
    localparam bit Bcast = 1'b1;
`else
    localparam bit Bcast = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        req_a, req_b, abort;
    logic [4:0]  req_col;
    logic [5:0]  req_frame;
    logic        ready_a, busy_a, err_a;
    logic        ready_b, busy_b, err_b;
    logic [35:0] strobe_a, strobe_b;
    logic [15:0] count_a, count_b;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [15:0] exp_cnt_a = 16'd0;
    logic [15:0] exp_cnt_b = 16'd0;

    frame_strobe_col_gen #(.ColId(3)) dut_a (
        .CLK(CLK), .RST(RST), .Req(req_a), .ReqCol(req_col), .ReqFrame(req_frame),
        .Ready(ready_a), .Abort(abort), .FrameStrobe_O(strobe_a), .Busy(busy_a),
        .ErrRange(err_a), .StrobeCount(count_a)
    );

    frame_strobe_col_gen #(.ColId(3), .SetupCycles(SetupB), .StrobeCycles(StrobeB)) dut_b (
        .CLK(CLK), .RST(RST), .Req(req_b), .ReqCol(req_col), .ReqFrame(req_frame),
        .Ready(ready_b), .Abort(abort), .FrameStrobe_O(strobe_b), .Busy(busy_b),
        .ErrRange(err_b), .StrobeCount(count_b)
    );

    // Free-running configuration clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One request on either instance, checked cycle by cycle against the timing rules
    task automatic run_txn(input bit use_b, input logic [4:0] col, input logic [5:0] frame,
                           input int abort_at, input string tag);
        int s, w, last;
        bit match, active, aborted;
        logic [35:0] one_hot, exp_strobe, act_strobe;
        logic exp_busy, exp_err, act_busy, act_ready, act_err;
        logic [15:0] act_count, exp_count;
        s       = use_b ? SetupB : 1;
        w       = use_b ? StrobeB : 1;
        match   = (col == ColIdTb) || (Bcast && (col == 5'h1F));
        active  = match && (frame < 6'd36);
        aborted = active && (abort_at >= 1) && (abort_at <= s + 1);
        one_hot = 36'd1 << frame;
        last    = s + w + 3;
        req_col   = col;
        req_frame = frame;
        if (use_b) req_b = 1'b1; else req_a = 1'b1;
        @(posedge CLK); #1;
        req_a = 1'b0;
        req_b = 1'b0;
        if (active && !aborted) begin
            if (use_b) exp_cnt_b = exp_cnt_b + 16'd1;
            else       exp_cnt_a = exp_cnt_a + 16'd1;
        end
        for (int t = 0; t <= last; t++) begin
            act_strobe = use_b ? strobe_b : strobe_a;
            act_busy   = use_b ? busy_b   : busy_a;
            act_ready  = use_b ? ready_b  : ready_a;
            act_err    = use_b ? err_b    : err_a;
            if (aborted) begin
                exp_busy   = (t < abort_at);
                exp_strobe = '0;
            end else if (active) begin
                exp_busy   = (t <= s + w + 1);
                exp_strobe = (t >= s + 1 && t <= s + w) ? one_hot : 36'd0;
            end else begin
                exp_busy   = 1'b0;
                exp_strobe = '0;
            end
            exp_err = match && !active && (t == 0);
            n_compared++;
            if (act_strobe !== exp_strobe) begin
                n_mismatched++;
                $display("[TB] FAIL %s strobe t=%0d: got %h expected %h", tag, t, act_strobe, exp_strobe);
            end
            n_compared++;
            if (act_busy !== exp_busy) begin
                n_mismatched++;
                $display("[TB] FAIL %s busy t=%0d: got %b expected %b", tag, t, act_busy, exp_busy);
            end
            n_compared++;
            if (act_ready !== !exp_busy) begin
                n_mismatched++;
                $display("[TB] FAIL %s ready t=%0d: got %b expected %b", tag, t, act_ready, !exp_busy);
            end
            n_compared++;
            if (act_err !== exp_err) begin
                n_mismatched++;
                $display("[TB] FAIL %s err_range t=%0d: got %b expected %b", tag, t, act_err, exp_err);
            end
            abort = (t + 1 == abort_at);
            @(posedge CLK); #1;
        end
        abort     = 1'b0;
        act_count = use_b ? count_b : count_a;
        exp_count = use_b ? exp_cnt_b : exp_cnt_a;
        n_compared++;
        if (act_count !== exp_count) begin
            n_mismatched++;
            $display("[TB] FAIL %s strobe_count: got %0d expected %0d", tag, act_count, exp_count);
        end
    endtask

    // Outputs while reset is held and right after it is released
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_compared++;
        if ({ready_a, ready_b, busy_a, busy_b, err_a, err_b} !== 6'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset flags: got %b expected 000000",
                     {ready_a, ready_b, busy_a, busy_b, err_a, err_b});
        end
        n_compared++;
        if ((strobe_a | strobe_b) !== 36'd0 || count_a !== 16'd0 || count_b !== 16'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset state: got strobe %h/%h count %0d/%0d expected zeros",
                     strobe_a, strobe_b, count_a, count_b);
        end
        RST = 1'b0;
        #1;
        n_compared++;
        if ({ready_a, ready_b} !== 2'b11) begin
            n_mismatched++;
            $display("[TB] FAIL reset release ready: got %b expected 11", {ready_a, ready_b});
        end
    endtask

    // Directed cases: basic strobe, wrong column, out-of-range frame, broadcast address
    task automatic test_directed();
        run_txn(1'b0, 5'd3, 6'd5, 0, "basic_a");
        run_txn(1'b0, 5'd4, 6'd5, 0, "no_match");
        run_txn(1'b0, 5'd3, 6'd40, 0, "range_err");
        run_txn(1'b0, 5'd3, 6'd35, 0, "top_frame");
        run_txn(1'b1, 5'd3, 6'd36, 0, "range_edge_b");
        run_txn(1'b0, 5'h1F, 6'd0, 0, "bcast");
    endtask

    // Abort in SETUP cancels; abort during STROBE is ignored
    task automatic test_abort();
        run_txn(1'b1, 5'd3, 6'd12, 2, "abort_setup");
        run_txn(1'b1, 5'd3, 6'd12, SetupB + 1, "abort_last_setup");
        run_txn(1'b1, 5'd3, 6'd12, SetupB + 2, "abort_strobe");
        run_txn(1'b1, 5'd3, 6'd7, 0, "basic_b");
    endtask

    // Req held high over three frames; frame changes while busy must be ignored
    task automatic test_back_to_back();
        logic [5:0]  frames[3];
        logic [35:0] seen[$];
        logic [35:0] prev;
        int idx, high_cycles;
        frames[0] = 6'd0;
        frames[1] = 6'd35;
        frames[2] = 6'd17;
        idx = 0;
        high_cycles = 0;
        prev = '0;
        req_col = 5'd3;
        req_frame = frames[0];
        req_a = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (req_a && ready_a) begin
                req_frame = frames[idx];
                idx++;
                exp_cnt_a = exp_cnt_a + 16'd1;
            end else begin
                req_frame = 6'($urandom_range(0, 35));
            end
            @(posedge CLK); #1;
            if (idx == 3) req_a = 1'b0;
            n_compared++;
            if ((strobe_a & (strobe_a - 36'd1)) !== 36'd0) begin
                n_mismatched++;
                $display("[TB] FAIL b2b one_hot: got %h expected at most one bit", strobe_a);
            end
            if (strobe_a != 36'd0) high_cycles++;
            if (strobe_a != 36'd0 && strobe_a != prev) seen.push_back(strobe_a);
            prev = strobe_a;
        end
        req_a = 1'b0;
        n_compared++;
        if (seen.size() != 3 || high_cycles != 3) begin
            n_mismatched++;
            $display("[TB] FAIL b2b pulses: got %0d pulses/%0d high cycles expected 3/3",
                     seen.size(), high_cycles);
        end
        for (int i = 0; i < 3; i++) begin
            n_compared++;
            if (i >= seen.size() || seen[i] !== (36'd1 << frames[i])) begin
                n_mismatched++;
                $display("[TB] FAIL b2b pulse%0d: got %h expected %h", i,
                         (i < seen.size()) ? seen[i] : 36'd0, 36'd1 << frames[i]);
            end
        end
        n_compared++;
        if (count_a !== exp_cnt_a) begin
            n_mismatched++;
            $display("[TB] FAIL b2b strobe_count: got %0d expected %0d", count_a, exp_cnt_a);
        end
    endtask

    // Reset landing while the strobe is high
    task automatic test_reset_mid_strobe();
        req_col = 5'd3;
        req_frame = 6'd9;
        req_b = 1'b1;
        @(posedge CLK); #1;
        req_b = 1'b0;
        repeat (SetupB + 1) @(posedge CLK);
        #1;
        n_compared++;
        if (strobe_b !== (36'd1 << 9)) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid strobe_before: got %h expected %h", strobe_b, 36'd1 << 9);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        exp_cnt_a = 16'd0;
        exp_cnt_b = 16'd0;
        n_compared++;
        if (strobe_b !== 36'd0 || busy_b !== 1'b0 || ready_b !== 1'b0 || count_b !== 16'd0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid at_edge: got strobe %h busy %b ready %b count %0d expected 0 0 0 0",
                     strobe_b, busy_b, ready_b, count_b);
        end
        RST = 1'b0;
        #1;
        n_compared++;
        if (ready_b !== 1'b1 || ready_a !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid ready_after: got %b%b expected 11", ready_a, ready_b);
        end
    endtask

    // Random requests on both instances with random aborts and columns
    task automatic test_random();
        logic [4:0] col;
        logic [5:0] frame;
        int pick, ab;
        for (int n = 0; n < 40; n++) begin
            pick  = int'($urandom_range(0, 3));
            col   = (pick < 2) ? ColIdTb : (pick == 2) ? 5'($urandom_range(0, 31)) : 5'h1F;
            frame = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(36, 63)) : 6'($urandom_range(0, 35));
            ab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            run_txn(1'($urandom_range(0, 1)), col, frame, ab, "random");
        end
    endtask

    // Test sequence
    initial begin
        RST = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        abort = 1'b0;
        req_col = '0;
        req_frame = '0;
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_reset_mid_strobe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
